// File: rtl/bf16_mul_norm_round_if.sv
// ---------------------------------------------------------------------------
// bf16_mul_norm_round_if
// Handshake bundle between the BF16 multiplier front end, the
// normalise/round stage and the downstream consumer.
//   in_*  : raw product fields with valid/ready (producer -> block)
//   out_* : packed BF16 result and range flags with valid/ready
//           (block -> consumer)
// Modports:
//   slave  : the normalise/round block
//   master : the environment that drives products and drains results
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface bf16_mul_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp_a;
  logic [7:0]  in_exp_b;
  logic [15:0] in_mant_prod;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  modport slave (
    input  in_valid, in_sign, in_exp_a, in_exp_b, in_mant_prod, in_zero,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_ovf, out_unf
  );

  modport master (
    output in_valid, in_sign, in_exp_a, in_exp_b, in_mant_prod, in_zero,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_ovf, out_unf
  );
endinterface

// File: rtl/bf16_mul_norm_round.sv
// ---------------------------------------------------------------------------
// bf16_mul_norm_round
// Back end of the BF16 multiplier: takes the raw significand product and
// the operand exponents, normalises, rounds (RNE or truncate), applies the
// exponent bias, resolves zero/inf/NaN and range limits, and packs a BF16
// word. Two registered stages, one result per cycle, backpressure-safe.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (drops all in-flight data)
//   bus  : slave side of bf16_mul_norm_round_if (in_* / out_* handshakes)
// Parameters:
//   BIAS     : exponent bias removed from ea+eb
//   ROUND_EN : 1 = round-to-nearest-even, 0 = truncate
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bf16_mul_norm_round #(
  parameter int BIAS     = 127,
  parameter bit ROUND_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  bf16_mul_norm_round_if.slave bus
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  // Returns {carry, mant}; a carry-out leaves mant wrapped to zero.
  function automatic logic [7:0] round_mant(input logic [6:0] mant,
                                            input logic       g,
                                            input logic       s);
    logic up;
    up = ROUND_EN && g && (s || mant[0]);
    return {1'b0, mant} + {7'd0, up};
  endfunction

  // Returns {ovf, unf, result}; specials outrank zero, which outranks range.
  function automatic logic [17:0] pack_result(input logic              sign,
                                              input logic              zero,
                                              input logic              spec,
                                              input logic signed [9:0] e,
                                              input logic [6:0]        mant);
    if (spec && zero)      return {2'b00, 16'h7FC0};
    else if (spec)         return {2'b00, sign, 8'hFF, 7'h00};
    else if (zero)         return {2'b00, sign, 15'h0000};
    else if (e >= 10'sd255) return {2'b10, sign, 8'hFF, 7'h00};
    else if (e <= 10'sd0)  return {2'b01, sign, 15'h0000};
    else                   return {2'b00, sign, e[7:0], mant};
  endfunction

  logic                vld_p1_q;
  logic                sign_p1_q, zero_p1_q, spec_p1_q, g_p1_q, s_p1_q;
  logic signed [9:0]   exp_p1_q;
  logic [6:0]          mant_p1_q;
  logic                vld_p2_q;
  logic [15:0]         res_p2_q;
  logic                ovf_p2_q, unf_p2_q;

  logic                s2_adv, acc_p0, hi_p0;
  logic signed [9:0]   exp_p1_d;
  logic [6:0]          mant_p1_d;
  logic                g_p1_d, s_p1_d;
  logic [7:0]          rnd_p1;
  logic signed [9:0]   exp_rnd_p1;
  logic [17:0]         pack_p2_d;

  // Stage 2 frees when empty or draining; stage 1 frees when stage 2 does.
  assign s2_adv       = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = !vld_p1_q || s2_adv;
  assign acc_p0       = bus.in_valid && bus.in_ready;

  // ---- stage 0 -> 1 : normalise to 1.xxxxxxx, split guard/sticky ----
  assign hi_p0     = bus.in_mant_prod[15];
  assign exp_p1_d  = signed'({2'b00, bus.in_exp_a}) + signed'({2'b00, bus.in_exp_b})
                   - BIAS_S + signed'({9'd0, hi_p0});
  assign mant_p1_d = hi_p0 ? bus.in_mant_prod[14:8] : bus.in_mant_prod[13:7];
  assign g_p1_d    = hi_p0 ? bus.in_mant_prod[7]    : bus.in_mant_prod[6];
  assign s_p1_d    = hi_p0 ? |bus.in_mant_prod[6:0] : |bus.in_mant_prod[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               vld_p1_q <= 1'b0;
    else if (bus.in_ready) vld_p1_q <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      sign_p1_q <= bus.in_sign;
      zero_p1_q <= bus.in_zero;
      spec_p1_q <= (bus.in_exp_a == 8'hFF) || (bus.in_exp_b == 8'hFF);
      exp_p1_q  <= exp_p1_d;
      mant_p1_q <= mant_p1_d;
      g_p1_q    <= g_p1_d;
      s_p1_q    <= s_p1_d;
    end
  end

  // ---- stage 1 -> 2 : round, re-adjust exponent, classify and pack ----
  assign rnd_p1     = round_mant(mant_p1_q, g_p1_q, s_p1_q);
  assign exp_rnd_p1 = exp_p1_q + signed'({9'd0, rnd_p1[7]});
  assign pack_p2_d  = pack_result(sign_p1_q, zero_p1_q, spec_p1_q, exp_rnd_p1, rnd_p1[6:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= 16'h0000;
      ovf_p2_q <= 1'b0;
      unf_p2_q <= 1'b0;
    end else if (s2_adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        ovf_p2_q <= pack_p2_d[17];
        unf_p2_q <= pack_p2_d[16];
        res_p2_q <= pack_p2_d[15:0];
      end
    end
  end

  assign bus.out_valid  = vld_p2_q;
  assign bus.out_result = res_p2_q;
  assign bus.out_ovf    = ovf_p2_q;
  assign bus.out_unf    = unf_p2_q;

endmodule

// File: tb/tb_bf16_mul_norm_round.sv
`timescale 1ns/1ps
module tb_bf16_mul_norm_round;
  localparam int BIAS = 127;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf16_mul_norm_round_if if0 ();
  bf16_mul_norm_round_if if1 ();

  bf16_mul_norm_round #(.BIAS(BIAS), .ROUND_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bf16_mul_norm_round #(.BIAS(BIAS), .ROUND_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // The truncating instance sees the same product stream and never stalls.
  assign if1.in_valid     = if0.in_valid;
  assign if1.in_sign      = if0.in_sign;
  assign if1.in_exp_a     = if0.in_exp_a;
  assign if1.in_exp_b     = if0.in_exp_b;
  assign if1.in_mant_prod = if0.in_mant_prod;
  assign if1.in_zero      = if0.in_zero;
  assign if1.out_ready    = 1'b1;

  typedef struct {
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [15:0] prod;
    logic        zero;
    logic        rne;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[15];
  vec_t items[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic sign, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [15:0] prod, input logic zero, input logic rne,
                              input logic [15:0] res, input logic ovf, input logic unf);
    vec_t v;
    v.sign = sign; v.ea = ea; v.eb = eb; v.prod = prod; v.zero = zero;
    v.rne = rne; v.res = res; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Reference: treat the product as an integer significand scaled by
  // 2^(ea+eb-BIAS-14), round it to 8 significant bits, then classify.
  function automatic logic [17:0] ref_model(input logic sign, input logic [7:0] ea,
                                            input logic [7:0] eb, input logic [15:0] prod,
                                            input logic zero, input logic rne);
    int msb, shift, kept, rem, half, e;
    logic spec;
    spec = (ea == 8'd255) || (eb == 8'd255);
    if (spec && zero) return {2'b00, 16'h7FC0};
    if (spec)         return {2'b00, sign, 8'hFF, 7'h00};
    if (zero)         return {2'b00, sign, 15'h0000};
    msb = 0;
    for (int i = 0; i < 16; i++) if (prod[i]) msb = i;
    shift = msb - 7;
    kept  = int'(prod) >> shift;
    rem   = int'(prod) - (kept << shift);
    half  = 1 << (shift - 1);
    if (rne && (rem > half || (rem == half && (kept % 2) == 1))) kept++;
    e = int'(ea) + int'(eb) - BIAS + (msb - 14);
    if (kept == 256) begin
      kept = 128;
      e++;
    end
    if (e >= 255) return {2'b10, sign, 8'hFF, 7'h00};
    if (e <= 0)   return {2'b01, sign, 15'h0000};
    return {2'b00, sign, e[7:0], kept[6:0]};
  endfunction

  task automatic drive(input logic v, input vec_t x, input logic ordy);
    if0.in_valid     = v;
    if0.in_sign      = x.sign;
    if0.in_exp_a     = x.ea;
    if0.in_exp_b     = x.eb;
    if0.in_mant_prod = x.prod;
    if0.in_zero      = x.zero;
    if0.out_ready    = ordy;
  endtask

  // Single product, no backpressure: exactly two cycles to out_valid.
  task automatic send_one(input vec_t x, input string nm);
    @(negedge clk);
    drive(1'b1, x, 1'b1);
    #1;
    chk({nm, "_in_ready"}, 32'(x.rne ? if0.in_ready : if1.in_ready), 32'(1));
    @(negedge clk);
    drive(1'b0, x, 1'b1);
    #1;
    chk({nm, "_early_valid"}, 32'(x.rne ? if0.out_valid : if1.out_valid), 32'(0));
    @(negedge clk);
    #1;
    chk({nm, "_valid"}, 32'(x.rne ? if0.out_valid : if1.out_valid), 32'(1));
    chk({nm, "_result"}, 32'(x.rne ? if0.out_result : if1.out_result), 32'(x.res));
    chk({nm, "_flags"}, 32'(x.rne ? {if0.out_ovf, if0.out_unf} : {if1.out_ovf, if1.out_unf}),
        32'({x.ovf, x.unf}));
  endtask

  // Streams 'items' into dut0; expected results queue up in order and the
  // block's capacity of two decides when in_ready must be low.
  task automatic stream(input bit scripted, input string nm);
    logic [17:0] expq[$];
    logic [17:0] got;
    int          idx, infl, cyc;
    logic        ordy, v;
    idx = 0; infl = 0; cyc = 0;
    while ((idx < items.size() || expq.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      ordy = scripted ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(0, 9) < 7);
      v    = (idx < items.size()) && (scripted || $urandom_range(0, 3) != 0);
      drive(v, items[(idx < items.size()) ? idx : 0], ordy);
      #1;
      chk({nm, "_in_ready"}, 32'(if0.in_ready), 32'(!(infl == 2 && !ordy)));
      if (if0.out_valid) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL %s_spurious: got out_valid=1 expected no pending result", nm);
        end else begin
          got = {if0.out_ovf, if0.out_unf, if0.out_result};
          chk({nm, "_out"}, 32'(got), 32'(expq[0]));
          if (ordy) begin
            void'(expq.pop_front());
            infl--;
          end
        end
      end
      if (v && if0.in_ready) begin
        expq.push_back(ref_model(items[idx].sign, items[idx].ea, items[idx].eb,
                                 items[idx].prod, items[idx].zero, 1'b1));
        idx++;
        infl++;
      end
      cyc++;
    end
    if (cyc >= 4000) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d results outstanding expected 0", nm, expq.size());
    end
    @(negedge clk);
    drive(1'b0, items[0], 1'b1);
  endtask

  initial begin
    vec_t x;
    logic [6:0] ma, mb;

    tbl[0]  = mk(0, 127, 127, 16'h4000, 0, 1, 16'h3F80, 0, 0);
    tbl[1]  = mk(0, 127, 127, 16'h9000, 0, 1, 16'h4010, 0, 0);
    tbl[2]  = mk(0, 127, 127, 16'h9181, 0, 1, 16'h4012, 0, 0);
    tbl[3]  = mk(0, 127, 127, 16'h9181, 0, 0, 16'h4011, 0, 0);
    tbl[4]  = mk(0, 127, 127, 16'h4A40, 0, 1, 16'h3F94, 0, 0);
    tbl[5]  = mk(1, 254, 254, 16'h4000, 0, 1, 16'hFF80, 1, 0);
    tbl[6]  = mk(0,  32,  32, 16'h4000, 0, 1, 16'h0000, 0, 1);
    tbl[7]  = mk(0, 255,   0, 16'h4000, 1, 1, 16'h7FC0, 0, 0);
    tbl[8]  = mk(1, 255, 127, 16'h4000, 0, 1, 16'hFF80, 0, 0);
    tbl[9]  = mk(1,   0, 127, 16'h4000, 1, 1, 16'h8000, 0, 0);
    tbl[10] = mk(0, 191, 191, 16'h4000, 0, 1, 16'h7F80, 1, 0);
    tbl[11] = mk(0, 254, 127, 16'h4000, 0, 1, 16'h7F00, 0, 0);
    tbl[12] = mk(0, 127, 127, 16'h7FFF, 0, 1, 16'h4000, 0, 0);
    tbl[13] = mk(0,  64,  64, 16'h4000, 0, 1, 16'h0080, 0, 0);
    tbl[14] = mk(0,  63,  64, 16'h4000, 0, 1, 16'h0000, 0, 1);

    rst = 1'b1;
    drive(1'b0, tbl[0], 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(if0.out_valid), 32'(0));
    chk("reset_out_result", 32'(if0.out_result), 32'(16'h0000));
    chk("reset_flags", 32'({if0.out_ovf, if0.out_unf}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(if0.in_ready), 32'(1));

    for (int i = 0; i < 15; i++) send_one(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: four back-to-back products with a three-cycle stall.
    items.delete();
    items.push_back(tbl[0]);
    items.push_back(tbl[1]);
    items.push_back(tbl[4]);
    items.push_back(tbl[5]);
    stream(1'b1, "stall");

    // Reset with both stages occupied.
    @(negedge clk);
    drive(1'b1, tbl[1], 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("full_in_ready", 32'(if0.in_ready), 32'(0));
    chk("full_out_valid", 32'(if0.out_valid), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(if0.out_valid), 32'(0));
    chk("midrst_out_result", 32'(if0.out_result), 32'(16'h0000));
    chk("midrst_flags", 32'({if0.out_ovf, if0.out_unf}), 32'(0));
    chk("midrst_in_ready", 32'(if0.in_ready), 32'(1));
    @(negedge clk);
    drive(1'b0, tbl[1], 1'b1);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(if0.in_ready), 32'(1));
    send_one(tbl[2], "postrst");

    // Randomised products with random gaps and backpressure.
    items.delete();
    for (int i = 0; i < 300; i++) begin
      ma = 7'($urandom_range(0, 127));
      mb = 7'($urandom_range(0, 127));
      x.sign = 1'($urandom_range(0, 1));
      x.ea   = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      x.eb   = ($urandom_range(0, 15) == 0) ? 8'd0   : 8'($urandom_range(0, 255));
      x.prod = 16'((128 + int'(ma)) * (128 + int'(mb)));
      x.zero = (x.ea == 8'd0) || (x.eb == 8'd0);
      x.rne  = 1'b1;
      x.res  = 16'h0000;
      x.ovf  = 1'b0;
      x.unf  = 1'b0;
      items.push_back(x);
    end
    stream(1'b0, "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
